// File: rtl/test_sequencer.sv
// Vector-driven test controller: fetches stimulus/expected pairs from a synchronous ROM,
// issues each stimulus over valid/ready, then scores the DUT result as pass, fail or timeout.
module test_sequencer #(
  parameter int WIDTH     = 8,
  parameter int NUM_TESTS = 16,
  parameter int ADDR_W    = 4,
  parameter int TO_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_vec_addr,
  input  logic [WIDTH-1:0]  i_vec_stim,
  input  logic [WIDTH-1:0]  i_vec_expct,
  output logic [WIDTH-1:0]  o_dut_stim,
  output logic              o_dut_valid,
  input  logic              i_dut_ready,
  input  logic [WIDTH-1:0]  i_dut_res,
  input  logic              i_dut_res_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_pass_cnt,
  output logic [ADDR_W:0]   o_fail_cnt,
  output logic [ADDR_W:0]   o_to_cnt,
  output logic              o_err_valid,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic [WIDTH-1:0]  o_err_actual
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RES,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TESTS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  // The timer fires on the edge where it would reach 2**TO_W-1.
  localparam logic [TO_W-1:0]   TO_LAST   = {{(TO_W - 1){1'b1}}, 1'b0};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [WIDTH-1:0]    r_stim;
  logic [WIDTH-1:0]    r_expct;
  logic [WIDTH-1:0]    r_res;
  logic [TO_W-1:0]     r_to;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     r_pass_cnt;
  logic [ADDR_W:0]     r_fail_cnt;
  logic [ADDR_W:0]     r_to_cnt;
  logic                r_err_valid;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [WIDTH-1:0]    r_err_actual;

  logic w_accept;
  logic w_timeout;
  logic w_advance;
  logic w_last;
  logic w_match;

  assign w_accept  = r_valid & i_dut_ready;
  assign w_timeout = (r_state == S_WAIT_RES) & ~i_dut_res_valid & (r_to == TO_LAST);
  assign w_advance = (r_state == S_CHECK) | w_timeout;
  assign w_last    = (r_addr == LAST_ADDR);
  assign w_match   = (r_res == r_expct);

  // NOTE: all state updates use <= so every register samples pre-edge values,
  // regardless of statement order inside this block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_stim       <= '0;
      r_expct      <= '0;
      r_res        <= '0;
      r_to         <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_to_cnt     <= '0;
      r_err_valid  <= 1'b0;
      r_err_addr   <= '0;
      r_err_actual <= '0;
    end else begin
      r_err_valid <= 1'b0;

      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state    <= S_FETCH;
            r_addr     <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_to_cnt   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        S_FETCH: begin
          r_stim  <= i_vec_stim;
          r_expct <= i_vec_expct;
          r_valid <= 1'b1;
          r_state <= S_ISSUE;
        end

        S_ISSUE: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_to    <= '0;
            r_state <= S_WAIT_RES;
          end
        end

        S_WAIT_RES: begin
          if (i_dut_res_valid) begin
            r_res   <= i_dut_res;
            r_state <= S_CHECK;
          end else if (w_timeout) begin
            r_to_cnt     <= r_to_cnt + CNT_ONE;
            r_err_valid  <= 1'b1;
            r_err_addr   <= r_addr;
            r_err_actual <= '0;
          end else begin
            r_to <= r_to + TO_ONE;
          end
        end

        S_CHECK: begin
          if (w_match) begin
            r_pass_cnt <= r_pass_cnt + CNT_ONE;
          end else begin
            r_fail_cnt   <= r_fail_cnt + CNT_ONE;
            r_err_valid  <= 1'b1;
            r_err_addr   <= r_addr;
            r_err_actual <= r_res;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // A timeout skips CHECK but moves on exactly as CHECK would.
      if (w_advance) begin
        if (w_last) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_addr  <= r_addr + ADDR_ONE;
          r_state <= S_FETCH;
        end
      end
    end
  end

  assign o_vec_addr   = r_addr;
  assign o_dut_stim   = r_stim;
  assign o_dut_valid  = r_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass_cnt   = r_pass_cnt;
  assign o_fail_cnt   = r_fail_cnt;
  assign o_to_cnt     = r_to_cnt;
  assign o_err_valid  = r_err_valid;
  assign o_err_addr   = r_err_addr;
  assign o_err_actual = r_err_actual;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: 4-vector ROM, scripted DUT responder, table of run scenarios
// plus a hand-written mid-run start/reset sequence.
module tb_test_sequencer;

  localparam int WIDTH     = 8;
  localparam int NUM_TESTS = 4;
  localparam int ADDR_W    = 4;
  localparam int TO_W      = 4;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start;
  logic [ADDR_W-1:0] o_vec_addr;
  logic [WIDTH-1:0]  i_vec_stim;
  logic [WIDTH-1:0]  i_vec_expct;
  logic [WIDTH-1:0]  o_dut_stim;
  logic              o_dut_valid;
  logic              i_dut_ready;
  logic [WIDTH-1:0]  i_dut_res;
  logic              i_dut_res_valid;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_pass_cnt;
  logic [ADDR_W:0]   o_fail_cnt;
  logic [ADDR_W:0]   o_to_cnt;
  logic              o_err_valid;
  logic [ADDR_W-1:0] o_err_addr;
  logic [WIDTH-1:0]  o_err_actual;

  test_sequencer #(
    .WIDTH(WIDTH), .NUM_TESTS(NUM_TESTS), .ADDR_W(ADDR_W), .TO_W(TO_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .o_vec_addr(o_vec_addr), .i_vec_stim(i_vec_stim), .i_vec_expct(i_vec_expct),
    .o_dut_stim(o_dut_stim), .o_dut_valid(o_dut_valid), .i_dut_ready(i_dut_ready),
    .i_dut_res(i_dut_res), .i_dut_res_valid(i_dut_res_valid),
    .o_busy(o_busy), .o_done(o_done),
    .o_pass_cnt(o_pass_cnt), .o_fail_cnt(o_fail_cnt), .o_to_cnt(o_to_cnt),
    .o_err_valid(o_err_valid), .o_err_addr(o_err_addr), .o_err_actual(o_err_actual)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [7:0] stim_tab  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] expct_tab [4] = '{8'hA1, 8'hB2, 8'h5A, 8'hC4};

  // ROM data settles within the FETCH cycle that follows an address change.
  assign i_vec_stim  = stim_tab[o_vec_addr[1:0]];
  assign i_vec_expct = expct_tab[o_vec_addr[1:0]];

  logic [42:0] all_outs;
  assign all_outs = {o_vec_addr, o_dut_stim, o_dut_valid, o_busy, o_done, o_pass_cnt,
                     o_fail_cnt, o_to_cnt, o_err_valid, o_err_addr, o_err_actual};

  typedef struct {
    string           name;
    logic [3:0][7:0] mask;   // result = expected ^ mask
    logic [3:0][7:0] dly;    // extra WAIT cycles before result; 8'hFF = never answer
    int              stall_idx;
    int              stall_n;
    int              exp_pass;
    int              exp_fail;
    int              exp_to;
    int              exp_errs;
    int              exp_err_addr;
    logic [7:0]      exp_err_act;
    int              exp_lat;  // acceptance edge to o_err_valid, last error
    int              exp_cycles;
  } vec_rec_t;

  vec_rec_t cur;
  int       run_id = 0;

  int         stim_bad;
  int         err_cnt;
  int         err_addr_seen;
  logic [7:0] err_act_seen;
  int         err_lat;
  int         acc_cyc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_rec_t base_rec(input string name, input int cycles);
    vec_rec_t r;
    r.name = name;  r.mask = '0;  r.dly = '0;  r.stall_idx = -1;  r.stall_n = 0;
    r.exp_pass = 4; r.exp_fail = 0; r.exp_to = 0; r.exp_errs = 0;
    r.exp_err_addr = 0; r.exp_err_act = 8'h00; r.exp_lat = 0; r.exp_cycles = cycles;
    return r;
  endfunction

  // DUT model: acts on falling edges so its outputs are stable around each rising edge.
  initial begin : responder
    int         seen_id;
    bit         pending;
    int         wait_left;
    logic [7:0] val;
    int         stall_cnt;
    logic [1:0] idx;
    seen_id = 0; pending = 0; wait_left = 0; val = '0; stall_cnt = 0;
    stim_bad = 0; err_cnt = 0; err_addr_seen = 0; err_act_seen = '0; err_lat = 0; acc_cyc = 0;
    i_dut_ready = 1'b1; i_dut_res_valid = 1'b0; i_dut_res = '0;
    forever begin
      @(negedge i_clk);
      if (run_id != seen_id) begin
        seen_id = run_id; stall_cnt = 0; stim_bad = 0; err_cnt = 0;
        err_addr_seen = 0; err_act_seen = '0; err_lat = 0;
      end
      i_dut_res_valid = 1'b0;
      idx = o_vec_addr[1:0];
      if (o_dut_valid && o_dut_stim !== stim_tab[idx]) stim_bad++;
      if (o_err_valid) begin
        err_cnt++;
        err_addr_seen = int'(o_err_addr);
        err_act_seen  = o_err_actual;
        err_lat       = cyc - acc_cyc;
      end
      if (pending) begin
        if (wait_left == 0) begin
          i_dut_res_valid = 1'b1;
          i_dut_res       = val;
          pending         = 0;
        end else begin
          wait_left--;
        end
      end
      if (o_dut_valid && int'(idx) == cur.stall_idx && stall_cnt < cur.stall_n) begin
        i_dut_ready = 1'b0;
        stall_cnt++;
      end else begin
        i_dut_ready = 1'b1;
      end
      if (o_dut_valid && i_dut_ready) begin
        acc_cyc = cyc + 1;
        if (cur.dly[idx] != 8'hFF) begin
          pending   = 1;
          wait_left = int'(cur.dly[idx]);
          val       = expct_tab[idx] ^ cur.mask[idx];
        end
      end
    end
  end

  // Entered and left at falling edge + 1.
  task automatic start_run(input vec_rec_t r, output int cyc0);
    cur = r;
    run_id++;
    i_start = 1'b1;
    @(negedge i_clk); #1;
    i_start = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic run_rec(input vec_rec_t r);
    int  cyc0;
    int  ncyc;
    bit  seen;
    start_run(r, cyc0);
    seen = 0;
    ncyc = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge i_clk); #1;
      if (o_done) begin
        seen = 1;
        ncyc = cyc - cyc0;
      end
    end
    check({r.name, "_done_seen"}, 64'(seen), 64'(1));
    check({r.name, "_cycles"}, 64'(ncyc), 64'(r.exp_cycles));
    check({r.name, "_busy_done"}, {o_busy, o_done}, 2'b01);
    check({r.name, "_pass"}, o_pass_cnt, 64'(r.exp_pass));
    check({r.name, "_fail"}, o_fail_cnt, 64'(r.exp_fail));
    check({r.name, "_to"}, o_to_cnt, 64'(r.exp_to));
    check({r.name, "_err_pulses"}, 64'(err_cnt), 64'(r.exp_errs));
    check({r.name, "_stim_bad"}, 64'(stim_bad), 64'(0));
    if (r.exp_errs > 0) begin
      check({r.name, "_err_addr"}, 64'(err_addr_seen), 64'(r.exp_err_addr));
      check({r.name, "_err_actual"}, err_act_seen, r.exp_err_act);
      check({r.name, "_err_lat"}, 64'(err_lat), 64'(r.exp_lat));
      check({r.name, "_err_addr_held"}, o_err_addr, 64'(r.exp_err_addr));
    end
  endtask

  vec_rec_t tab [10];

  initial begin : main
    vec_rec_t slow;
    int       cyc0;
    bit       found;

    i_rst_n = 1'b0;
    i_start = 1'b0;
    cur     = base_rec("idle", 0);

    tab[0] = base_rec("all_pass", 16);
    tab[1] = base_rec("mismatch_v2", 16);
    tab[1].mask[2] = 8'h01;  tab[1].exp_pass = 3;  tab[1].exp_fail = 1;  tab[1].exp_errs = 1;
    tab[1].exp_err_addr = 2; tab[1].exp_err_act = 8'h5B; tab[1].exp_lat = 2;
    tab[2] = base_rec("timeout_v1", 29);
    tab[2].dly[1] = 8'hFF;   tab[2].exp_pass = 3;  tab[2].exp_to = 1;    tab[2].exp_errs = 1;
    tab[2].exp_err_addr = 1; tab[2].exp_err_act = 8'h00; tab[2].exp_lat = 15;
    tab[3] = base_rec("stall_v0", 26);
    tab[3].stall_idx = 0;    tab[3].stall_n = 10;
    tab[4] = base_rec("stall_long_v2", 36);
    tab[4].stall_idx = 2;    tab[4].stall_n = 20;
    tab[5] = base_rec("coinc_pass_v3", 30);
    tab[5].dly[3] = 8'd14;
    tab[6] = base_rec("coinc_fail_v0", 30);
    tab[6].dly[0] = 8'd14;   tab[6].mask[0] = 8'hFF; tab[6].exp_pass = 3; tab[6].exp_fail = 1;
    tab[6].exp_errs = 1;     tab[6].exp_err_addr = 0; tab[6].exp_err_act = 8'h5E; tab[6].exp_lat = 16;
    tab[7] = base_rec("late_v1", 29);
    tab[7].dly[1] = 8'd13;
    tab[8] = base_rec("mixed", 29);
    tab[8].mask[0] = 8'h0F;  tab[8].dly[3] = 8'hFF;  tab[8].exp_pass = 2; tab[8].exp_fail = 1;
    tab[8].exp_to = 1;       tab[8].exp_errs = 2;    tab[8].exp_err_addr = 3;
    tab[8].exp_err_act = 8'h00; tab[8].exp_lat = 15;
    tab[9] = base_rec("all_fail", 16);
    tab[9].mask = {8'h80, 8'h80, 8'h80, 8'h80};
    tab[9].exp_pass = 0;     tab[9].exp_fail = 4;    tab[9].exp_errs = 4;
    tab[9].exp_err_addr = 3; tab[9].exp_err_act = 8'h44; tab[9].exp_lat = 2;

    repeat (3) @(negedge i_clk);
    #1;
    check("reset_outputs", all_outs, 64'(0));
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    check("idle_outputs", all_outs, 64'(0));

    for (int i = 0; i < 10; i++) run_rec(tab[i]);

    // Mid-run start is ignored; reset in WAIT_RES aborts to reset values.
    slow = base_rec("midrun", 0);
    slow.dly[1] = 8'd10;
    start_run(slow, cyc0);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge i_clk); #1;
      if (o_vec_addr == 4'd1 && o_dut_valid) found = 1;
    end
    check("midrun_reach_v1", 64'(found), 64'(1));
    repeat (2) @(negedge i_clk);
    #1;
    i_start = 1'b1;
    @(negedge i_clk); #1;
    i_start = 1'b0;
    check("midrun_start_ignored", {o_vec_addr, o_pass_cnt, o_busy, o_done, o_dut_valid},
          {4'd1, 5'd1, 1'b1, 1'b0, 1'b0});
    i_rst_n = 1'b0;
    #1;
    check("midrun_async_reset", all_outs, 64'(0));
    repeat (2) @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    // The stale result from the aborted vector lands while idle.
    repeat (12) @(negedge i_clk);
    #1;
    check("post_reset_idle", all_outs, 64'(0));
    run_rec(tab[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
Hardware test controller for FRANK6000 bring-up. It walks a table of stimulus/expected-result vectors held in an external synchronous ROM and issues each stimulus to the device under test (DUT) through a valid/ready handshake. It then waits for the DUT result under a timeout, compares the result against the expected value and accumulates pass/fail/timeout counts. It is the synthesizable counterpart of the simulation pass/fail checking, intended for FPGA self-test.

Parameters:
WIDTH, 8, data width of stimulus, expected value and DUT result
NUM_TESTS, 16, number of vectors run per start (1..2**ADDR_W)
ADDR_W, 4, vector ROM address width
TO_W, 8, timeout counter width; timeout fires after 2**TO_W-1 cycles

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; begins a run when idle
o_vec_addr  out  ADDR_W  vector ROM address
i_vec_stim  in  WIDTH  ROM stimulus data, valid one cycle after o_vec_addr changes
i_vec_expct  in  WIDTH  ROM expected data, same timing as i_vec_stim
o_dut_stim  out  WIDTH  stimulus to DUT
o_dut_valid  out  1  stimulus valid
i_dut_ready  in  1  DUT accepts stimulus
i_dut_res  in  WIDTH  DUT result
i_dut_res_valid  in  1  DUT result valid (single-cycle)
o_busy  out  1  run in progress
o_done  out  1  run complete; held until next start
o_pass_cnt  out  ADDR_W+1  passing vectors this run
o_fail_cnt  out  ADDR_W+1  mismatching vectors this run
o_to_cnt  out  ADDR_W+1  timed-out vectors this run
o_err_valid  out  1  one-cycle pulse per fail or timeout
o_err_addr  out  ADDR_W  vector index of the error
o_err_actual  out  WIDTH  DUT result on fail; 0 on timeout

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; internal timeout counter 0.
- States: IDLE, FETCH, ISSUE, WAIT_RES, CHECK, DONE.
- IDLE/DONE: on i_start go to FETCH. Also on i_start: o_vec_addr=0, all three counters cleared, o_done=0, o_busy=1. i_start is ignored in every other state.
- FETCH: one cycle covering the ROM latency. Next cycle, register i_vec_stim into o_dut_stim and i_vec_expct internally, then go to ISSUE.
- ISSUE: o_dut_valid=1, with o_dut_stim stable until accepted. Go to WAIT_RES on the cycle where o_dut_valid & i_dut_ready. o_dut_valid drops the following cycle. No timeout applies in ISSUE; a DUT that never asserts ready stalls the sequencer.
- WAIT_RES: the timeout counter increments every cycle from 0.
  - On i_dut_res_valid: capture i_dut_res and go to CHECK.
  - Otherwise, when the counter reaches 2**TO_W-1: increment o_to_cnt, pulse o_err_valid with o_err_actual=0, and go to CHECK-skip, i.e. advance exactly as CHECK does without comparing.
  - If i_dut_res_valid arrives in the same cycle as the terminal count, the result wins and no timeout is counted.
- CHECK: one cycle.
  - Captured result == expected: o_pass_cnt+1.
  - Mismatch: o_fail_cnt+1, and in the same cycle o_err_valid=1, o_err_addr=current index, o_err_actual=captured value.
  - Then, if the index equals NUM_TESTS-1, go to DONE (o_busy=0, o_done=1). Otherwise increment o_vec_addr and go to FETCH.
- The o_err_* fields hold their last values between pulses.
- A result valid arriving outside WAIT_RES is ignored.
- Counters never wrap: the maximum value NUM_TESTS fits in ADDR_W+1 bits. Invariant at DONE: pass+fail+to = NUM_TESTS.
- Reset asserted mid-run aborts immediately to reset values, with no partial done.
- Latency per vector, DUT answering instantly: FETCH 1, ISSUE 1, WAIT_RES 1, CHECK 1, i.e. 4 cycles minimum.

Test Plan:
1. NUM_TESTS=4, ready always 1, result = expected one cycle after acceptance -> o_done after 16 cycles; pass=4, fail=0, to=0; no o_err_valid pulse.
2. Vector 2 expects 8'h5A, DUT returns 8'h5B -> exactly one o_err_valid; o_err_addr=2, o_err_actual=8'h5B; fail=1, pass=3.
3. DUT never returns a result for vector 1 (TO_W=4) -> o_err_valid 15 cycles after acceptance; o_err_addr=1, o_err_actual=0; to=1; run completes.
4. i_dut_ready held low 10 cycles on vector 0 -> o_dut_valid and o_dut_stim stable throughout; no timeout counted; run still passes.
5. Result valid coincident with the timeout terminal count -> counted as pass or fail, to=0.
6. i_start pulsed mid-run, then reset asserted mid-WAIT_RES -> start ignored; after reset all outputs 0, state IDLE; a new start runs cleanly from address 0.
